// File: rtl/td4_register_file_pkg.sv
// Shared constants for the TD4 register set: data width and LOAD bit positions.
package td4_pkg;

  localparam int unsigned DATA_W = 4;

  // Bit positions within the active-low LOAD vector
  localparam int unsigned LD_A  = 0;
  localparam int unsigned LD_B  = 1;
  localparam int unsigned LD_C  = 2;
  localparam int unsigned LD_PC = 3;

  localparam int unsigned LOAD_W = 4;

endpackage : td4_pkg

// File: rtl/td4_register_file_if.sv
// Register-file bus: load enables and shared load data in, register contents out.
//   load     : active-low per-register load enables (A, B, C, PC)
//   in_data  : shared load data (ALU result)
//   out_a/out_b/out_c : general and output-port registers
//   address  : program counter (instruction ROM address)
interface td4_register_file_if
  import td4_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
);

  logic [LOAD_W-1:0] load;
  logic [WIDTH-1:0]  in_data;
  logic [WIDTH-1:0]  out_a;
  logic [WIDTH-1:0]  out_b;
  logic [WIDTH-1:0]  out_c;
  logic [WIDTH-1:0]  address;

  // Controller side: drives loads/data, observes registers
  modport master (
    output load, in_data,
    input  out_a, out_b, out_c, address
  );

  // Register-file side
  modport slave (
    input  load, in_data,
    output out_a, out_b, out_c, address
  );

endinterface : td4_register_file_if

// File: rtl/td4_register_file_load_counter.sv
// 74HC161-style register: async active-low clear, active-low parallel load,
// count-up when enabled and not loading.
//   clk    : clock
//   clr_n  : asynchronous active-low clear
//   load_n : active-low synchronous parallel load (wins over counting)
//   cnt_en : count enable
//   d      : parallel load data
//   q      : register contents
module td4_load_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load_n,
  input  logic             cnt_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (!load_n) begin
      q <= d;
    end else if (cnt_en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule : td4_load_counter

// File: rtl/td4_register_file.sv
// TD4 architectural registers: A, B, output port C and the program counter.
// Each register loads the shared in_data when its LOAD bit is low; the PC
// otherwise counts up every clock, wrapping modulo 2^WIDTH.
//   clk : system clock
//   rst : asynchronous active-low reset, clears all registers
//   bus : td4_register_file_if slave (load, in_data in; out_a/b/c, address out)
module td4_register_file
  import td4_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  td4_register_file_if.slave   bus
);

  logic [WIDTH-1:0] q_a;
  logic [WIDTH-1:0] q_b;
  logic [WIDTH-1:0] q_c;
  logic [WIDTH-1:0] q_pc;

  // Data registers hold when not loaded
  td4_load_counter #(.WIDTH(WIDTH)) u_reg_a (
    .clk    (clk),
    .clr_n  (rst),
    .load_n (bus.load[LD_A]),
    .cnt_en (1'b0),
    .d      (bus.in_data),
    .q      (q_a)
  );

  td4_load_counter #(.WIDTH(WIDTH)) u_reg_b (
    .clk    (clk),
    .clr_n  (rst),
    .load_n (bus.load[LD_B]),
    .cnt_en (1'b0),
    .d      (bus.in_data),
    .q      (q_b)
  );

  td4_load_counter #(.WIDTH(WIDTH)) u_reg_c (
    .clk    (clk),
    .clr_n  (rst),
    .load_n (bus.load[LD_C]),
    .cnt_en (1'b0),
    .d      (bus.in_data),
    .q      (q_c)
  );

  // Program counter: jump on load, otherwise always increments
  td4_load_counter #(.WIDTH(WIDTH)) u_reg_pc (
    .clk    (clk),
    .clr_n  (rst),
    .load_n (bus.load[LD_PC]),
    .cnt_en (1'b1),
    .d      (bus.in_data),
    .q      (q_pc)
  );

  assign bus.out_a   = q_a;
  assign bus.out_b   = q_b;
  assign bus.out_c   = q_c;
  assign bus.address = q_pc;

endmodule : td4_register_file

// File: tb/tb_td4_register_file.sv
// Self-checking bench for td4_register_file: a reference model predicts the
// register state for each driven cycle, pushes it to a scoreboard queue, and
// the entry is popped and compared after the capturing clock edge.
module tb_td4_register_file;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] pc;
  } regs_t;

  logic clk;
  logic rst;

  td4_register_file_if #(.WIDTH(W)) bus ();

  td4_register_file #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks   = 0;
  int    n_failures = 0;
  regs_t model;
  regs_t sb_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input regs_t exp);
    check({tag, ".a"},  bus.out_a,   exp.a);
    check({tag, ".b"},  bus.out_b,   exp.b);
    check({tag, ".c"},  bus.out_c,   exp.c);
    check({tag, ".pc"}, bus.address, exp.pc);
  endtask

  // Reference model of one rising edge with the current inputs
  function automatic regs_t next_state(input regs_t cur, input logic r,
                                       input logic [3:0] ld, input logic [W-1:0] d);
    regs_t n;
    n = cur;
    if (!r) begin
      n = '0;
    end else begin
      if (!ld[0]) n.a = d;
      if (!ld[1]) n.b = d;
      if (!ld[2]) n.c = d;
      if (!ld[3]) n.pc = d;
      else        n.pc = n.pc + 4'd1;
    end
    return n;
  endfunction

  // Drive one cycle: predict, push, clock, pop and compare
  task automatic step(input string tag, input logic [3:0] ld, input logic [W-1:0] d);
    regs_t exp;
    bus.load    = ld;
    bus.in_data = d;
    model = next_state(model, rst, ld, d);
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      exp = sb_q.pop_front();
      check_all(tag, exp);
    end
  endtask

  initial begin
    rst         = 1'b0;
    bus.load    = 4'b1111;
    bus.in_data = 4'b1010;
    model       = '0;

    // Reset state before any edge
    #2;
    check_all("rst_init", '0);

    // Held in reset over several edges
    for (int i = 0; i < 3; i++) step("rst_hold", 4'b1111, 4'b1010);

    // Individual loads
    rst = 1'b1;
    step("load_a", 4'b1110, 4'b1010);
    step("load_b", 4'b1101, 4'b1010);

    // Output port and jump
    step("load_c", 4'b1011, 4'b1100);
    step("jump",   4'b0111, 4'b1100);
    step("inc",    4'b1111, 4'b1100);

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    check_all("rst_async", '0);
    model = '0;

    // PC count and wrap from reset
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 17; i++) step("count", 4'b1111, 4'(i));

    // Simultaneous load of all four
    step("load_all", 4'b0000, 4'b0101);

    // Source/destination in one cycle: A takes pre-edge data
    step("hazard", 4'b1110, 4'b0110);

    // Reset dominates a coinciding load
    rst = 1'b0;
    #1;
    model = '0;
    step("rst_prio", 4'b0000, 4'b1111);
    rst = 1'b1;
    step("rst_release", 4'b0000, 4'b1111);
    step("after_release", 4'b1111, 4'b0000);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule : tb_td4_register_file
